// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters (for
// example the CPU MMIO TX path and a hardware debug/status reporter).
// Arbitration is round-robin at packet granularity: once a requester is
// granted it owns the transmitter until its byte flagged "last" is accepted,
// so packets from different sources never interleave on the serial line.
// The data path is purely combinational: no buffering, no added latency.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, a lock whose owner leaves req_valid low for LOCK_TIMEOUT
//   locked cycles is forcibly released and timeout_err pulses for one cycle.
//   Cycles where the owner is valid but the transmitter is not ready never
//   count. When undefined, timeout_err is tied low and a lock is held for as
//   long as the owner takes to send its last byte.
//
// Parameters:
//   NUM_REQ       number of requesters, 2..8
//   LOCK_TIMEOUT  idle-cycle limit for a locked owner (timeout build only)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester k on bits [8k+7:8k]
//   req_last     per-requester "final byte of packet" flag
//   req_ready    per-requester accept (only the owner can see it high)
//   tx_data      byte towards the transmitter data_in
//   tx_valid     valid towards the transmitter
//   tx_ready     ready from the transmitter
//   grant_id     index of the current owner, meaningful while busy=1
//   busy         a requester holds the lock
//   timeout_err  one-cycle pulse when a lock is forcibly released
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;

    // Signals of the currently granted requester, selected by grant_id_q.
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;

    // Round-robin candidate computed from the live request vector.
    logic [GW-1:0]   winner;
    logic            winner_found;

    logic            handshake;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // ------------------------------------------------------------------------
    // Owner select: pick valid/last/data of the requester named by grant_id_q.
    // A compare-per-requester mux keeps the index arithmetic constant.
    // ------------------------------------------------------------------------
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_q == GW'(k)) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_data  = req_data[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first set request strictly above last_grant_q, and if
    // there is none, wrap around to the lowest set request at or below it.
    // Two passes avoid a modulo on a non-power-of-two NUM_REQ.
    // ------------------------------------------------------------------------
    always_comb begin
        winner       = last_grant_q;
        winner_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winner_found && req_valid[k] && (GW'(k) > last_grant_q)) begin
                winner       = GW'(k);
                winner_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winner_found && req_valid[k] && (GW'(k) <= last_grant_q)) begin
                winner       = GW'(k);
                winner_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit-side outputs. Idle drives nothing; locked forwards the owner's
    // byte straight through and routes tx_ready back to the owner only.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state_q == LOCKED) begin
            tx_valid = sel_valid;
            tx_data  = sel_data;
            for (int k = 0; k < NUM_REQ; k++) begin
                req_ready[k] = (grant_id_q == GW'(k)) && tx_ready;
            end
        end
    end

    assign handshake = (state_q == LOCKED) && sel_valid && tx_ready;

    // ------------------------------------------------------------------------
    // Next-state logic. Granting always costs one idle cycle, which also gives
    // the guaranteed gap between packets. The lock ends on the accepted last
    // byte (or, in the timeout build, when the owner has gone silent too long);
    // either way the owner becomes last_grant so it loses the next tie.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d = winner;
                    state_d    = LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            LOCKED: begin
                if (handshake) begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (sel_last) begin
                        last_grant_d = grant_id_q;
                        state_d      = IDLE;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!sel_valid) begin
                    // Only owner silence counts; a transmitter stall with the
                    // owner valid falls outside this branch.
                    if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d       = IDLE;
                        last_grant_d  = grant_id_q;
                        timeout_err_d = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. last_grant resets to the top index so requester 0 wins
    // the first arbitration after reset. A reset mid-packet simply abandons it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Timeout bookkeeping: idle counter and the registered release pulse,
    // which lines up with the first cycle busy is low again.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Without the timeout feature the limit has no effect on the hardware.
    logic unused_lock_timeout;
    assign unused_lock_timeout = ^LOCK_TIMEOUT;
    assign timeout_err         = 1'b0;
`endif

    assign busy     = (state_q == LOCKED);
    assign grant_id = grant_id_q;

endmodule
